// File: rtl/sum_accumulator.sv
// Counts N_SAMPLES accepted sums into an ACC_W accumulator, then holds the result.
// SUM_ACCUMULATOR_SAT_EN selects saturation on carry out instead of wrap.
module sum_accumulator #(
    parameter int DATA_W    = 9,
    parameter int ACC_W     = 16,
    parameter int N_SAMPLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] X,
    output logic [ACC_W-1:0]  acc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic              busy
);

    localparam int CNT_W = $clog2(N_SAMPLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W:0]     sum;
    logic               accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (accept && cnt_q == LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Carry out of the ACC_W-bit add is the overflow condition.
    always_comb begin
        sum   = {1'b0, acc_q} + (ACC_W + 1)'(X);
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (state_q == IDLE && start) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
            ovf_d = ovf_q | sum[ACC_W];
`ifdef SUM_ACCUMULATOR_SAT_EN
            acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
            acc_d = sum[ACC_W-1:0];
`endif
        end
    end

    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        accept    = in_valid && in_ready;
        acc       = acc_q;
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: three parameterisations share one stimulus stream
// and are checked every cycle against an integer model plus literal pins.
module tb_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [8:0]  X;
    logic        out_ready;
    logic [2:0]  ir, ov, of, bz;
    logic [15:0] acc0;
    logic [9:0]  acc1;
    logic [15:0] acc2;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sum_accumulator u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(ir[0]), .X(X), .acc(acc0), .out_valid(ov[0]),
        .out_ready(out_ready), .overflow(of[0]), .busy(bz[0])
    );

    sum_accumulator #(.ACC_W(10), .N_SAMPLES(3)) u_sm (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(ir[1]), .X(X), .acc(acc1), .out_valid(ov[1]),
        .out_ready(out_ready), .overflow(of[1]), .busy(bz[1])
    );

    sum_accumulator #(.N_SAMPLES(1)) u_n1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(ir[2]), .X(X), .acc(acc2), .out_valid(ov[2]),
        .out_ready(out_ready), .overflow(of[2]), .busy(bz[2])
    );

`ifdef SUM_ACCUMULATOR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // Model: phase 0 waiting, 1 collecting, 2 result held.
    int     aw [3] = '{16, 10, 16};
    int     ns [3] = '{8, 3, 1};
    int     m_ph [3];
    int     m_cnt [3];
    longint m_acc [3];
    bit     m_ovf [3];
    bit     m_init = 1'b0;

    function automatic longint dut_acc(input int i);
        case (i)
            0:       return longint'(acc0);
            1:       return longint'(acc1);
            default: return longint'(acc2);
        endcase
    endfunction

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    always begin
        longint s, mx;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_ph[i] = 0; m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
            end else begin
                case (m_ph[i])
                    0: if (start) begin
                        m_ph[i] = 1; m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
                    end
                    1: if (in_valid) begin
                        s  = m_acc[i] + longint'(X);
                        mx = (longint'(1) << aw[i]) - 1;
                        if (s > mx) begin
                            m_ovf[i] = 1;
                            s = SAT ? mx : s - (mx + 1);
                        end
                        m_acc[i] = s;
                        m_cnt[i]++;
                        if (m_cnt[i] == ns[i]) m_ph[i] = 2;
                    end
                    default: if (out_ready) m_ph[i] = 0;
                endcase
            end
        end
        if (rst) m_init = 1'b1;
        #1;
        if (m_init) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("acc[%0d]", i), dut_acc(i), m_acc[i]);
                chk($sformatf("in_ready[%0d]", i), longint'(ir[i]), longint'(m_ph[i] == 1));
                chk($sformatf("out_valid[%0d]", i), longint'(ov[i]), longint'(m_ph[i] == 2));
                chk($sformatf("busy[%0d]", i), longint'(bz[i]), longint'(m_ph[i] != 0));
                chk($sformatf("overflow[%0d]", i), longint'(of[i]), longint'(m_ovf[i]));
            end
        end
    end

    task automatic cyc(input bit s, input bit v, input int x, input bit o);
        @(negedge clk);
        start = s; in_valid = v; X = 9'(x); out_ready = o;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 0; in_valid = 0; X = 0; out_ready = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        settle();
        chk("rst_acc", longint'(acc0), 0);
        chk("rst_busy", longint'(bz[0]), 0);
        chk("rst_in_ready", longint'(ir[0]), 0);

        // eight back-to-back beats of 100
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 8; k++) cyc(0, 1, 100, 0);
        settle();
        chk("b2b_valid", longint'(ov[0]), 1);
        chk("b2b_acc", longint'(acc0), 800);
        chk("b2b_ovf", longint'(of[0]), 0);

        // stall in DONE with start/in_valid noise
        for (int k = 0; k < 5; k++) cyc(1, 1, 7, 0);
        settle();
        chk("hold_acc", longint'(acc0), 800);
        chk("hold_valid", longint'(ov[0]), 1);
        chk("hold_in_ready", longint'(ir[0]), 0);
        cyc(1, 0, 0, 1);
        settle();
        chk("release_busy", longint'(bz[0]), 0);
        chk("release_acc", longint'(acc0), 800);
        cyc(0, 0, 0, 0);
        settle();
        chk("no_restart", longint'(bz[0]), 0);

        // overflow on the 10-bit instance
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 1, 511, 0);
        settle();
        chk("ovf_acc", longint'(acc1), SAT ? 1023 : 509);
        chk("ovf_flag", longint'(of[1]), 1);
        for (int k = 0; k < 5; k++) cyc(0, 1, 511, 0);
        settle();
        chk("big_acc", longint'(acc0), 4088);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);

        // sparse valid pattern 1,0,0,...
        cyc(1, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 1, k, 0);
            if (k < 8) begin
                cyc(0, 0, int'($urandom_range(0, 511)), 0);
                cyc(0, 0, int'($urandom_range(0, 511)), 0);
            end
        end
        settle();
        chk("sparse_acc", longint'(acc0), 36);
        chk("sparse_valid", longint'(ov[0]), 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);

        // reset mid-run
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 1, 5, 0);
        @(negedge clk);
        rst = 1'b1; start = 1; in_valid = 1; out_ready = 1;
        settle();
        chk("midrst_busy", longint'(bz[0]), 0);
        chk("midrst_acc", longint'(acc0), 0);
        chk("midrst_valid", longint'(ov[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 8; k++) cyc(0, 1, 2, 0);
        settle();
        chk("after_rst_acc", longint'(acc0), 16);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);

        // single-sample instance
        cyc(1, 0, 0, 0);
        cyc(0, 1, 300, 0);
        settle();
        chk("n1_valid", longint'(ov[2]), 1);
        chk("n1_acc", longint'(acc2), 300);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 99) == 0);
            start     = ($urandom_range(0, 3) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            X         = 9'($urandom_range(0, 511));
            out_ready = $urandom_range(0, 1) == 1;
        end
        @(negedge clk);
        rst = 0; start = 0; in_valid = 0; out_ready = 0;
        settle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter DATA_W, default 9, width of incoming sum (carry-inclusive adder result).
REQ-002 Parameter ACC_W, default 16, accumulator width; SHALL satisfy ACC_W >= DATA_W.
REQ-003 Parameter N_SAMPLES, default 8, sums accepted per accumulation; SHALL be >= 1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  begin new accumulation; sampled only in IDLE.
REQ-007 in_valid  input  1  X carries a valid sum this cycle.
REQ-008 in_ready  output  1  block accepts X this cycle.
REQ-009 X  input  DATA_W  unsigned sum from upstream adder stage.
REQ-010 acc  output  ACC_W  accumulated value (running during ACCUM, final in DONE).
REQ-011 out_valid  output  1  acc holds final result.
REQ-012 out_ready  input  1  downstream consumes result.
REQ-013 overflow  output  1  sticky flag: accumulator exceeded 2^ACC_W-1 this run.
REQ-014 busy  output  1  high whenever state != IDLE.

Function
REQ-015 FSM states IDLE, ACCUM, DONE; all outputs registered or decoded from state only (no combinational input->output path).
REQ-016 IDLE: start=1 -> ACCUM next cycle; acc, beat counter, overflow cleared to 0 on that edge.
REQ-017 ACCUM: in_ready=1; beat accepted when in_valid && in_ready; acc <= acc + zero-extend(X); counter increments.
REQ-018 Cycles with in_valid=0 in ACCUM: acc and counter unchanged, in_ready stays 1.
REQ-019 On acceptance of beat N_SAMPLES -> DONE; out_valid=1 from the following cycle (latency 1 cycle after final beat).
REQ-020 DONE: in_ready=0, acc and overflow held stable; out_valid held until out_ready=1.
REQ-021 DONE with out_ready=1 -> IDLE next cycle; out_valid deasserts; acc retains final value until next start.
REQ-022 start ignored in ACCUM and DONE, including when coincident with out_ready in DONE (a new run needs start in IDLE).
REQ-023 in_ready=0 in IDLE and DONE; in_valid ignored there.
REQ-024 Beat counter width ceil(log2(N_SAMPLES+1)); N_SAMPLES=1 goes ACCUM->DONE on first accepted beat.
REQ-025 Overflow detect: carry out of ACC_W-bit add sets overflow; stays set until next start or reset.

Reset
REQ-026 rst=1 at a clock edge: state IDLE, acc=0, counter=0, overflow=0, out_valid=0, in_ready=0, busy=0.
REQ-027 rst has priority over start, in_valid and out_ready in the same cycle.
REQ-028 rst mid-ACCUM or in DONE abandons the run; partial result discarded, no out_valid produced.

Configuration
REQ-029 Macro SUM_ACCUMULATOR_SAT_EN.
REQ-030 Defined: on carry out acc saturates to all-ones (2^ACC_W-1) and stays there for remaining beats of the run; overflow set.
REQ-031 Undefined: acc wraps modulo 2^ACC_W; overflow set; subsequent beats add to wrapped value.
REQ-032 Handshake timing, latency and all other behaviour identical in both builds.

Verification
REQ-033 Defaults, start, 8 beats X=100 back-to-back -> out_valid 1 cycle after 8th beat, acc=800, overflow=0, busy high throughout.
REQ-034 ACC_W=10, N_SAMPLES=3, X=511 x3 -> wrap build: acc=509, overflow=1; SAT_EN build: acc=1023, overflow=1.
REQ-035 Defaults, in_valid toggled 1,0,0,1,... with X=1..8 on valid beats only -> acc=36; counter/acc frozen on invalid cycles.
REQ-036 DONE with out_ready low 5 cycles, start and in_valid pulsed -> acc/out_valid stable, in_ready=0, no new run; out_ready=1 -> IDLE next cycle.
REQ-037 rst asserted after 3 accepted beats -> next cycle IDLE, acc=0, out_valid never asserted; subsequent start + 8x X=2 -> acc=16.
REQ-038 N_SAMPLES=1, start then single beat X=300 -> out_valid next cycle, acc=300.
